// File: rtl/seg_mon60.sv
// seg_mon60: decodes sampled 2-digit 7-seg display back to BCD/binary and checks mod-60 stepping (clk, clr async; sample, seg_g, seg_s in; bcd_g, bcd_s, value, valid, locked, pat_err, seq_err, err_cnt out)
module seg_mon60 #(
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sample,
    input  logic [0:6]       seg_g,
    input  logic [0:6]       seg_s,
    output logic [3:0]       bcd_g,
    output logic [3:0]       bcd_s,
    output logic [5:0]       value,
    output logic             valid,
    output logic             locked,
    output logic             pat_err,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} st_t;
    localparam logic [3:0] LN = 4'(LOCK_N);
    st_t st;
    logic [5:0] prev, v, succ;
    logic [3:0] acq_cnt, nxt;
    logic [4:0] dg, ds;
    logic good;
    function automatic logic [4:0] dec(input logic [0:6] p);
        case (p)
            7'b1111110: dec = 5'h10;
            7'b0110000: dec = 5'h11;
            7'b1101101: dec = 5'h12;
            7'b1111001: dec = 5'h13;
            7'b0110011: dec = 5'h14;
            7'b1011011: dec = 5'h15;
            7'b1011111: dec = 5'h16;
            7'b1110000: dec = 5'h17;
            7'b1111111: dec = 5'h18;
            7'b1111011: dec = 5'h19;
            default:    dec = 5'h00;
        endcase
    endfunction
    always_comb begin
        dg   = dec(seg_g);
        ds   = dec(seg_s);
        good = dg[4] & ds[4] & (ds[3:0] <= 4'd5);
        v    = 6'(ds[3:0]) * 6'd10 + 6'(dg[3:0]);
        succ = prev == 6'd59 ? 6'd0 : prev + 6'd1;
        nxt  = acq_cnt + 4'd1;
    end
    assign locked = st == LOCKED;
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            st      <= IDLE;
            prev    <= '0;
            acq_cnt <= '0;
            bcd_g   <= '0;
            bcd_s   <= '0;
            value   <= '0;
            valid   <= 1'b0;
            pat_err <= 1'b0;
            seq_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            pat_err <= 1'b0;
            seq_err <= 1'b0;
            if (sample) begin
                valid <= good;
                if (!good) begin
                    pat_err <= 1'b1;
                    st      <= IDLE;
                    if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                end else begin
                    bcd_g <= dg[3:0];
                    bcd_s <= ds[3:0];
                    value <= v;
                    prev  <= v;
                    case (st)
                        IDLE: begin
                            st      <= ACQ;
                            acq_cnt <= '0;
                        end
                        ACQ: begin
                            acq_cnt <= v == succ ? nxt : 4'd0;
                            if (v == succ && nxt == LN) st <= LOCKED;
                        end
                        default: if (v != succ) begin
                            seq_err <= 1'b1;
                            st      <= ACQ;
                            acq_cnt <= '0;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_seg_mon60.sv
// tb_seg_mon60: randomized and directed check of seg_mon60 against a behavioural model
module tb_seg_mon60;
    localparam int LOCK_N = 2;
    localparam logic [0:6] TBL [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic clk = 0, clr = 1, sample = 0;
    logic [0:6] seg_g = '0, seg_s = '0;
    logic [3:0] bcd_g, bcd_s, bcd_g2, bcd_s2;
    logic [5:0] value, value2;
    logic valid, locked, pat_err, seq_err, valid2, locked2, pat_err2, seq_err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    int total = 0, bad = 0;
    int m_mode, m_prev, m_cnt, m_g, m_s, m_val, m_valid, m_pat, m_seq, m_err8, m_err2;

    seg_mon60 #(.LOCK_N(LOCK_N), .ERR_W(8)) dut (
        .clk(clk), .clr(clr), .sample(sample), .seg_g(seg_g), .seg_s(seg_s),
        .bcd_g(bcd_g), .bcd_s(bcd_s), .value(value), .valid(valid), .locked(locked),
        .pat_err(pat_err), .seq_err(seq_err), .err_cnt(err_cnt));
    seg_mon60 #(.LOCK_N(LOCK_N), .ERR_W(2)) dut2 (
        .clk(clk), .clr(clr), .sample(sample), .seg_g(seg_g), .seg_s(seg_s),
        .bcd_g(bcd_g2), .bcd_s(bcd_s2), .value(value2), .valid(valid2), .locked(locked2),
        .pat_err(pat_err2), .seq_err(seq_err2), .err_cnt(err_cnt2));

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
        end
    endtask

    function automatic int dec(input logic [0:6] p);
        for (int i = 0; i < 10; i++) if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_cnt = 0; m_g = 0; m_s = 0; m_val = 0;
        m_valid = 0; m_pat = 0; m_seq = 0; m_err8 = 0; m_err2 = 0;
    endtask

    task automatic model_step();
        int dg, ds, v;
        bit good;
        dg = dec(seg_g);
        ds = dec(seg_s);
        good = dg >= 0 && ds >= 0 && ds <= 5;
        v = ds * 10 + dg;
        m_pat = 0;
        m_seq = 0;
        if (!sample) return;
        m_valid = good;
        if (!good) begin
            m_pat = 1;
            m_mode = 0;
        end else begin
            m_g = dg; m_s = ds; m_val = v;
            if (m_mode == 0) begin
                m_mode = 1; m_cnt = 0;
            end else if (v == (m_prev + 1) % 60) begin
                m_cnt++;
                if (m_mode == 1 && m_cnt == LOCK_N) m_mode = 2;
            end else begin
                m_seq = m_mode == 2;
                m_mode = 1; m_cnt = 0;
            end
            m_prev = v;
        end
        if (m_pat || m_seq) begin
            if (m_err8 < 255) m_err8++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    always @(posedge clk) begin
        if (!clr) model_step();
        #1;
        if (!clr) begin
            chk("bcd_g", bcd_g, m_g);
            chk("bcd_s", bcd_s, m_s);
            chk("value", value, m_val);
            chk("valid", valid, m_valid);
            chk("locked", locked, m_mode == 2);
            chk("pat_err", pat_err, m_pat);
            chk("seq_err", seq_err, m_seq);
            chk("err_cnt", err_cnt, m_err8);
            chk("err_cnt2", err_cnt2, m_err2);
            chk("value2", value2, m_val);
        end
    end

    task automatic step(input bit s, input logic [0:6] g, input logic [0:6] t);
        @(negedge clk);
        sample = s; seg_g = g; seg_s = t;
        @(posedge clk);
        #2;
    endtask

    task automatic smp(input int v);
        step(1, TBL[v % 10], TBL[v / 10]);
    endtask

    task automatic idle();
        step(0, seg_g, seg_s);
    endtask

    task automatic do_clr();
        @(posedge clk);
        #3;
        clr = 1;
        #1;
        model_reset();
        chk("clr_value", value, 0);
        chk("clr_bcd", {bcd_s, bcd_g}, 0);
        chk("clr_valid", valid, 0);
        chk("clr_locked", locked, 0);
        chk("clr_pulses", {pat_err, seq_err}, 0);
        chk("clr_err", err_cnt, 0);
        chk("clr_err2", err_cnt2, 0);
        @(negedge clk);
        sample = 0;
        clr = 0;
    endtask

    initial begin
        int cur, r;
        model_reset();
        #12;
        do_clr();
        smp(57); smp(58); smp(59);
        chk("lit_lock59", locked, 1);
        smp(0);
        chk("lit_wrap_seq", seq_err, 0);
        smp(1);
        chk("lit_val1", value, 1);
        chk("lit_err0", err_cnt, 0);
        do_clr();
        smp(21); smp(22); smp(23);
        chk("lit_lock23", locked, 1);
        smp(25);
        chk("lit_skip_seq", seq_err, 1);
        chk("lit_skip_err", err_cnt, 1);
        chk("lit_skip_lock", locked, 0);
        chk("lit_skip_val", value, 25);
        smp(26);
        chk("lit_seq_pulse1", seq_err, 0);
        smp(27);
        chk("lit_relock", locked, 1);
        do_clr();
        smp(8); smp(9); smp(10);
        step(1, 7'b0000000, TBL[1]);
        chk("lit_blank_pat", pat_err, 1);
        chk("lit_blank_valid", valid, 0);
        chk("lit_blank_val", value, 10);
        chk("lit_blank_lock", locked, 0);
        smp(12);
        chk("lit_after_seq", seq_err, 0);
        chk("lit_after_valid", valid, 1);
        step(1, TBL[1], TBL[6]);
        chk("lit_oor_pat", pat_err, 1);
        chk("lit_oor_valid", valid, 0);
        chk("lit_oor_val", value, 12);
        do_clr();
        repeat (5) begin
            step(1, 7'b0000000, 7'b0000000);
            chk("lit_sat_pat", pat_err2, 1);
        end
        chk("lit_sat2", err_cnt2, 3);
        chk("lit_sat8", err_cnt, 5);
        do_clr();
        cur = 0;
        repeat (800) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                cur = (cur + 1) % 60;
                smp(cur);
            end else if (r < 70) begin
                cur = $urandom_range(0, 59);
                smp(cur);
            end else if (r < 75) smp(cur);
            else if (r < 85) idle();
            else if (r < 92) step(1, 7'($urandom), TBL[$urandom_range(0, 5)]);
            else step(1, TBL[$urandom_range(0, 9)], TBL[$urandom_range(6, 9)]);
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_mon60.md
# seg_mon60

Seven-segment readback monitor for the two-digit mod-60 display path. It samples the units and tens segment patterns driven to the display on a strobe and decodes them back to BCD and binary. It then checks that successive samples advance by exactly one modulo 60, flagging bad patterns and sequence breaks. It sits beside the display driver on the same clock as a built-in self-check for the seconds/minutes counter chain.

## Interface
- LOCK_N, 2: consecutive correct increments required in ACQ before entering LOCKED (1..15)
- ERR_W, 8: width of the saturating error counter
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-high
- sample  in  1  strobe; segments are captured on a rising clk edge while high
- seg_g  in  [0:6]  units-digit segments, bit 0 = a … bit 6 = g, active-high
- seg_s  in  [0:6]  tens-digit segments, same encoding
- bcd_g  out  4  last valid units digit
- bcd_s  out  4  last valid tens digit
- value  out  6  last valid value in binary, 10*bcd_s + bcd_g (0..59)
- valid  out  1  last sample decoded valid and in range
- locked  out  1  monitor in LOCKED state
- pat_err  out  1  one-cycle pulse: sampled pattern invalid or out of range
- seq_err  out  1  one-cycle pulse: valid value is not the successor while LOCKED
- err_cnt  out  ERR_W  count of pat_err plus seq_err pulses, saturating at all-ones

## Operation
- Decode table, segments a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Any other pattern is invalid, including blank 0000000.
- A sample is good when both digits decode and tens ≤ 5. A tens value of 6..9 counts as a pattern error.
- successor(v) = v+1, except successor(59) = 0.
- Internal state: prev[5:0] and acq_cnt[3:0].
- State IDLE:
  - good sample -> ACQ, prev=value, acq_cnt=0
  - bad sample -> pat_err, stay IDLE
- State ACQ:
  - good sample equal to successor(prev) -> acq_cnt+1 and prev=value; when the new count reaches LOCK_N -> LOCKED
  - good sample not equal to successor -> stay ACQ, prev=value, acq_cnt=0, no seq_err
  - bad sample -> pat_err, go to IDLE
- State LOCKED:
  - good successor -> stay LOCKED
  - good non-successor (including a repeated value) -> seq_err, go to ACQ with prev=value and acq_cnt=0
  - bad sample -> pat_err, go to IDLE
- Output updates:
  - bcd_g, bcd_s and value update only on good samples and hold on bad samples.
  - valid follows the good/bad result of the most recent sample and holds between samples.
- err_cnt increments by 1 on each pat_err or seq_err pulse and stops at 2^ERR_W−1. At most one of pat_err and seq_err is high in any cycle.
- While sample is low: no state change and no pulses.

## Timing
- Reset (clr high, asynchronous): state IDLE, prev=0, acq_cnt=0. All outputs 0, including bcd_g, bcd_s, value, valid, locked, pat_err, seq_err and err_cnt.
- clr asserted mid-operation takes effect immediately. It also clears err_cnt.
- All outputs are registered. The effect of a sample at edge N is visible after edge N: bcd/value/valid/locked/pulses are valid in the cycle following the sampling edge.
- pat_err and seq_err are high for exactly one cycle per offending sample. Back-to-back offending samples give pulses in consecutive cycles.
- locked rises in the cycle after the LOCK_N-th consecutive correct increment. It falls in the cycle after the offending sample.
- sample held high for several cycles means one sample per cycle. No edge detection is performed.
- Segment inputs are sampled only on sampling edges and need only be stable around the edge.

## Test plan
- Reset: assert clr mid-cycle -> all outputs 0 immediately, locked=0, err_cnt=0.
- Clean run, LOCK_N=2: sample 57,58,59,00,01 -> locked=1 after the 59 sample; 59->00 wrap gives no seq_err; value=1 at end, err_cnt=0.
- Skip: locked at 23, sample 25 -> seq_err pulse one cycle, err_cnt=1, locked=0, value=25. Then 26,27 -> locked=1.
- Invalid pattern: locked at 10, sample units=0000000 -> pat_err, valid=0, value holds 10, state IDLE. Next sample 12 -> ACQ, no seq_err.
- Out of range: sample tens=1011111 (6), units=0110000 (1) -> pat_err, valid=0, value unchanged.
- Saturation, ERR_W=2: five consecutive bad samples -> err_cnt reaches 3 and holds. Then clr -> err_cnt=0.
